// File: rtl/cbus_arbiter_if.sv
// Shared cbus request/response types and the bundle of requester/memory-side
// buses that the arbiter sits between.
package cbus_pkg;
   // Burst length encoded as beats-1.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      mlen_t       len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

interface cbus_arbiter_if import cbus_pkg::*; #(parameter int NUM_REQ = 2);
   cbus_req_t  ireqs  [NUM_REQ];
   cbus_resp_t iresps [NUM_REQ];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   // master: the caches plus the memory bridge; slave: the arbiter itself
   modport master (output ireqs, input iresps, input oreq, output oresp);
   modport slave  (input ireqs, output iresps, output oreq, input oresp);
endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus memory port among NUM_REQ cache
// requesters; a grant is held until the beat carrying ready&last.
//
// state | meaning
// IDLE  | no burst owned; arbitrate among valid requesters from rr_ptr
// BUSY  | requester sel owns the bus; request/response passed through
module cbus_arbiter import cbus_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             resetn,
   cbus_arbiter_if.slave    bus,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx,
   output logic [7:0]       beat_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] sel, sel_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [7:0]       beat_nxt;

   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W:0]   cand;

   // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = rr_ptr;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!win_found && bus.ireqs[cand[IDX_W-1:0]].valid) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         sel      <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   // beat_cnt is cleared only on a new grant so the last count stays visible.
   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      rr_ptr_nxt = rr_ptr;
      beat_nxt   = beat_cnt;
      if (state == IDLE) begin
         if (win_found) begin
            state_nxt = BUSY;
            sel_nxt   = win_idx;
            beat_nxt  = '0;
         end
      end else begin
         if (bus.oresp.ready) begin
            if (beat_cnt != 8'hff)
               beat_nxt = beat_cnt + 8'd1;
            if (bus.oresp.last) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + IDX_W'(1);
            end
         end
      end
   end

   // Non-owners always see an all-zero response, data included.
   always_comb begin
      bus.oreq = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         bus.iresps[j] = '0;
         if (state == BUSY && sel == IDX_W'(j))
            bus.iresps[j] = bus.oresp;
      end
      if (state == BUSY)
         bus.oreq = bus.ireqs[sel];
   end

   assign busy      = (state == BUSY);
   assign grant_idx = sel;

   a_owner_holds_valid: assert property (@(posedge clk) disable iff (!resetn)
      (state == BUSY) |-> bus.ireqs[sel].valid);

endmodule
